// File: rtl/usb_tx_sequencer.sv
// +----------------------------------------------------------------------------+
// | usb_tx_sequencer: snapshots an averaged-channel frame and streams it out   |
// | byte-wise over valid/ready, followed by a CRC-16/USB trailer. Rev 1.0      |
// +----------------------------------------------------------------------------+
`default_nettype none

module usb_tx_sequencer #(
  parameter int NUM_CH = 16,
  parameter int WORD_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NUM_CH*WORD_W-1:0] frame_in,
  input  logic                     tx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     frame_drop
);

  localparam int FW     = NUM_CH * WORD_W;
  localparam int NBYTES = FW / 8;
  localparam int CW     = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, CRC_LO, CRC_HI} state_t;

  // Reflected CRC-16/USB, one byte consumed LSB-first.
  function automatic logic [15:0] crc16_usb(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     crc_q, crc_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic            drop_q, drop_d;

  logic            xfer;
  logic [15:0]     crc_next;
  logic [FW-1:0]   shadow_shr;

  assign xfer       = valid_q && tx_ready;
  assign crc_next   = crc16_usb(crc_q, data_q);
  // The shadow is consumed by shifting, so the next byte is always at the bottom.
  assign shadow_shr = shadow_q >> 8;

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    crc_d    = crc_q;
    data_d   = data_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    drop_d   = start && (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = frame_in;
          data_d   = frame_in[7:0];
          valid_d  = 1'b1;
          crc_d    = 16'hFFFF;
          cnt_d    = '0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          crc_d    = crc_next;
          cnt_d    = cnt_q + CW'(1);
          shadow_d = shadow_shr;
          if (cnt_q == LAST_BYTE) begin
            data_d  = ~crc_next[7:0];
            state_d = CRC_LO;
          end else begin
            data_d  = shadow_shr[7:0];
          end
        end
      end
      CRC_LO: begin
        if (xfer) begin
          data_d  = ~crc_q[15:8];
          state_d = CRC_HI;
        end
      end
      CRC_HI: begin
        if (xfer) begin
          data_d  = 8'h00;
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      cnt_q    <= '0;
      crc_q    <= 16'hFFFF;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      crc_q    <= crc_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
    end
  end

  assign tx_data    = data_q;
  assign tx_valid   = valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign frame_drop = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_usb_tx_sequencer: scoreboard bench for usb_tx_sequencer. Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_usb_tx_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, tx_ready;
  logic [511:0] frame_in;
  logic [7:0]   tx_data;
  logic         tx_valid, busy, done, frame_drop;

  logic         start9, ready9;
  logic [71:0]  frame9;
  logic [7:0]   data9;
  logic         valid9, busy9, done9, drop9;

  usb_tx_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start), .frame_in(frame_in), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .busy(busy), .done(done), .frame_drop(frame_drop)
  );

  usb_tx_sequencer #(.NUM_CH(9), .WORD_W(8)) u_dut9 (
    .clk(clk), .rst(rst), .start(start9), .frame_in(frame9), .tx_ready(ready9),
    .tx_data(data9), .tx_valid(valid9), .busy(busy9), .done(done9), .frame_drop(drop9)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp9_q[$];
  int  done_cnt = 0;
  bit  rand_ready = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic push_frame(input logic [511:0] f);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      b = f[i*8 +: 8];
      exp_q.push_back(b);
      c = crc_upd(c, b);
    end
    exp_q.push_back(~c[7:0]);
    exp_q.push_back(~c[15:8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s timeout busy=%0b expected=0", name, busy);
    end
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor for the default-size DUT.
  logic [7:0] held;
  bit stalled = 0;
  bit prev_done = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (stalled) begin
        check("stall_hold_data", 32'(tx_data), 32'(held));
        check("stall_hold_valid", 32'(tx_valid), 32'd1);
      end
      check("valid_eq_busy", 32'(tx_valid), 32'(busy));
      if (!tx_valid) check("idle_data_zero", 32'(tx_data), 32'd0);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h expected=none", tx_data);
        end else begin
          check("byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
      end
      stalled   = tx_valid && !tx_ready;
      held      = tx_data;
      prev_done = done;
    end else begin
      stalled   = 0;
      prev_done = 0;
    end
  end

  // Monitor for the 9x8 DUT.
  always @(negedge clk) begin
    if (!rst && valid9 && ready9) begin
      if (exp9_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL t1_unexpected_byte actual=%0h expected=none", data9);
      end else begin
        check("t1_byte", 32'(data9), 32'(exp9_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] fa, fb, fc;
    int n, dc, d0;

    rst = 1'b1; start = 1'b0; tx_ready = 1'b1; frame_in = '0;
    start9 = 1'b0; ready9 = 1'b1; frame9 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_drop", 32'(frame_drop), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_valid9", 32'(valid9), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // T1: "123456789" through a 9x8 instance.
    for (int i = 0; i < 9; i++) frame9[i*8 +: 8] = 8'(8'h31 + i);
    for (int i = 0; i < 9; i++) exp9_q.push_back(8'(8'h31 + i));
    exp9_q.push_back(8'hC8);
    exp9_q.push_back(8'hB4);
    start9 = 1'b1;
    @(posedge clk);
    #1 start9 = 1'b0;
    n = 0;
    @(negedge clk);
    while (valid9 && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("t1_valid_cycles", 32'(n), 32'd11);
    check("t1_done", 32'(done9), 32'd1);
    check("t1_queue_left", 32'(exp9_q.size()), 32'd0);

    // T2: defaults, channel k = k*0x11 in the low byte.
    for (int k = 0; k < 16; k++) fa[k*32 +: 32] = 32'(k * 17);
    frame_in = fa;
    push_frame(fa);
    @(posedge clk);
    #1;
    pulse_start();
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t2_busy_cycles", 32'(n), 32'd66);
    check("t2_done", 32'(done), 32'd1);

    // T3: same frame, random back-pressure.
    @(posedge clk);
    #1;
    push_frame(fa);
    d0 = done_cnt;
    rand_ready = 1;
    pulse_start();
    @(negedge clk);
    wait_idle(1000, "t3_finish");
    rand_ready = 0;
    @(posedge clk);
    #1 tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

    // T4/T6: start held through a frame, frame_in altered right after snapshot.
    fb = ~fa;
    push_frame(fa);
    push_frame(fb);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 frame_in = fb;
    dc = 0;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      if (frame_drop) dc++;
      n++;
      @(negedge clk);
    end
    if (frame_drop) dc++;
    check("t4_done", 32'(done), 32'd1);
    check("t4_drop_count", 32'(dc), 32'd66);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("t4_second_busy", 32'(busy), 32'd1);
    wait_idle(200, "t4_second_finish");
    repeat (2) @(negedge clk);
    check("t4_no_drop_after", 32'(frame_drop), 32'd0);

    // T5: reset after byte 20 accepted, then a clean frame.
    for (int k = 0; k < 16; k++) fc[k*32 +: 32] = 32'h0102_0304 * 32'(k + 3);
    frame_in = fc;
    push_frame(fc);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    pulse_start();
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t5_valid_after_rst", 32'(tx_valid), 32'd0);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    check("t5_data_after_rst", 32'(tx_data), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    fc = {fc[255:0], fc[511:256]} ^ 512'h5A;
    frame_in = fc;
    push_frame(fc);
    @(posedge clk);
    #1;
    pulse_start();
    @(negedge clk);
    wait_idle(200, "t5_second_finish");
    repeat (3) @(negedge clk);
    check("t5_second_done", 32'(done_cnt - d0), 32'd1);

    check("queue_left", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
